// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared sizes, slot index type and inactive-level helpers for the LED matrix scanner
package led_matrix_pkg;
  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  typedef logic [2:0] col_idx_t;
  localparam logic [NUM_COLS-1:0] COL_ALL = '1;
  localparam logic [NUM_ROWS-1:0] ROW_ALL = '1;
  function automatic logic [NUM_COLS-1:0] col_off(input bit active_low);
    return active_low ? COL_ALL : '0;
  endfunction
  function automatic logic [NUM_ROWS-1:0] row_off(input bit active_low);
    return active_low ? ROW_ALL : '0;
  endfunction
endpackage

// File: rtl/led_matrix_scanner_scan_timer.sv
// scan_timer: slot divider and column index; outputs describe the state after the coming edge
module scan_timer
  import led_matrix_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  output col_idx_t nxt_idx,
  output logic     slot_start,
  output logic     frame_edge,
  output logic     blank
);
  localparam int DW = $clog2(CLK_DIV);
  if (CLK_DIV < 2) begin : g_bad_div
    $error("scan_timer: CLK_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
    $error("scan_timer: BLANK_CYCLES must be < CLK_DIV");
  end
  logic [DW-1:0] div_cnt, nxt_div;
  col_idx_t col_idx;
  logic running, wrap;
  // a frame starts on the first enabled edge after being idle, or on wrap out of the last column
  always_comb begin
    wrap = div_cnt == DW'(CLK_DIV - 1);
    frame_edge = en && (!running || (wrap && col_idx == col_idx_t'(NUM_COLS - 1)));
    nxt_div = (!en || frame_edge || wrap) ? '0 : div_cnt + 1'b1;
    nxt_idx = (!en || frame_edge) ? '0 : wrap ? col_idx + 3'd1 : col_idx;
    slot_start = nxt_div == '0;
    blank = !en || nxt_div < DW'(BLANK_CYCLES);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt <= '0;
      col_idx <= '0;
      running <= 1'b0;
    end else begin
      div_cnt <= nxt_div;
      col_idx <= nxt_idx;
      running <= en;
    end
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: frame-snapshotted column multiplexer driving a 7x5 LED matrix
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int BLANK_CYCLES   = 1,
  parameter bit COL_ACTIVE_LOW = 1'b1,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_ROWS-1:0] col1_in,
  input  logic [NUM_ROWS-1:0] col2_in,
  input  logic [NUM_ROWS-1:0] col3_in,
  input  logic [NUM_ROWS-1:0] col4_in,
  input  logic [NUM_ROWS-1:0] col5_in,
  output logic [NUM_COLS-1:0] col_sel,
  output logic [NUM_ROWS-1:0] row_data,
  output col_idx_t            col_idx,
  output logic                frame_start
);
  localparam logic [NUM_COLS-1:0] COL_OFF = col_off(COL_ACTIVE_LOW);
  localparam logic [NUM_ROWS-1:0] ROW_OFF = row_off(ROW_ACTIVE_LOW);
  col_idx_t nxt_idx;
  logic slot_start, frame_edge, blank;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] in_pat, shadow;
  logic [NUM_ROWS-1:0] pat;
  logic [NUM_COLS-1:0] onehot;
  scan_timer #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .en(en),
    .nxt_idx(nxt_idx),
    .slot_start(slot_start),
    .frame_edge(frame_edge),
    .blank(blank)
  );
  assign in_pat = {col5_in, col4_in, col3_in, col2_in, col1_in};
  // bypass the shadow on the snapshot edge so an unblanked first slot shows the fresh frame
  always_comb begin
    pat = frame_edge ? in_pat[nxt_idx] : shadow[nxt_idx];
    onehot = NUM_COLS'(1) << nxt_idx;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '0;
      col_sel <= COL_OFF;
      row_data <= ROW_OFF;
      col_idx <= '0;
      frame_start <= 1'b0;
    end else begin
      if (frame_edge) shadow <= in_pat;
      if (slot_start) col_idx <= nxt_idx;
      frame_start <= frame_edge;
      col_sel <= blank ? COL_OFF : COL_OFF ^ onehot;
      row_data <= blank ? ROW_OFF : ROW_OFF ^ pat;
    end
endmodule
